// File: rtl/hazard_scoreboard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard_pkg
//   Shared definitions for the hazard scoreboard: register-bank encoding,
//   register index width, default capacity of the multi-cycle unit, and a
//   small register-reference type with helpers used for hazard matching.
// -----------------------------------------------------------------------------
package hazard_scoreboard_pkg;

   localparam int   REG_IDX_W               = 5;
   localparam int   NUM_REGS                = 1 << REG_IDX_W;
   localparam logic BANK_INT                = 1'b0;
   localparam logic BANK_FP                 = 1'b1;
   localparam int   DEFAULT_MAX_OUTSTANDING = 4;
   localparam int   DEFAULT_CNT_W           = 3;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   // A register is identified by its index together with its bank.
   typedef struct packed {
      logic     bank;
      reg_idx_t idx;
   } reg_ref_t;

   // Integer x0 is hard-wired to zero: it is never busy and never matches.
   function automatic logic is_int_x0(input reg_ref_t r);
      return (r.bank == BANK_INT) && (r.idx == '0);
   endfunction

   function automatic logic ref_match(input reg_ref_t a, input reg_ref_t b);
      return (a.bank == b.bank) && (a.idx == b.idx);
   endfunction

endpackage

// File: rtl/hazard_scoreboard_bank.sv
// -----------------------------------------------------------------------------
// scoreboard_bank
//   Busy bits for one register bank (32 entries). One register is marked busy
//   per cycle through the set port and one is released through the clear port;
//   when both target the same entry the set wins. Three lookup ports report
//   whether a source register is still pending, already treating an entry
//   being cleared this cycle as free (the register file is write-first).
//
//   Ports
//     clk_i, reset_i   clock, synchronous active-high reset
//     set_en, set_idx  mark set_idx busy at the next edge
//     clr_en, clr_idx  release clr_idx at the next edge
//     lookup_idx[3]    source indices to test
//     lookup_busy[3]   registered busy bit with completion bypass applied
//     busy             registered busy vector
//
//   ZERO_REG0 = 1 ties entry 0 to zero (integer bank).
// -----------------------------------------------------------------------------
module scoreboard_bank
   import hazard_scoreboard_pkg::*;
#(
   parameter bit ZERO_REG0 = 1'b0
) (
   input  logic                    clk_i,
   input  logic                    reset_i,
   input  logic                    set_en,
   input  reg_idx_t                set_idx,
   input  logic                    clr_en,
   input  reg_idx_t                clr_idx,
   input  logic [2:0][REG_IDX_W-1:0] lookup_idx,
   output logic [2:0]              lookup_busy,
   output logic [NUM_REGS-1:0]     busy
);

   logic [NUM_REGS-1:0] busy_q;
   logic [NUM_REGS-1:0] busy_d;

   // NOTE: every combinational output gets a default before any conditional
   // update so no latch is inferred; blocking '=' is used inside always_comb.
   always_comb begin
      busy_d = busy_q;
      if (clr_en) busy_d[clr_idx] = 1'b0;
      // Applied after the clear so a same-register set wins.
      if (set_en) busy_d[set_idx] = 1'b1;
      if (ZERO_REG0) busy_d[0] = 1'b0;
   end

   // NOTE: sequential state uses non-blocking '<=' so all registers update
   // together at the edge; the whole vector is reset, it is small flop state.
   always_ff @(posedge clk_i) begin
      if (reset_i) busy_q <= '0;
      else         busy_q <= busy_d;
   end

   always_comb begin
      lookup_busy = '0;
      for (int i = 0; i < 3; i++) begin
         lookup_busy[i] = busy_q[lookup_idx[i]] &
                          ~(clr_en && (clr_idx == lookup_idx[i]));
      end
   end

   assign busy = busy_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//   Sits beside the ID stage and tracks destination registers of in-flight
//   multi-cycle operations in the integer and FP banks. Raises stall_o when the
//   instruction in ID cannot proceed: RAW/WAW against a pending multi-cycle
//   result, load-use against a load in EX, or the multi-cycle unit full.
//
//   Ports
//     clk_i, reset_i              clock, synchronous active-high reset
//     id_valid_i                  valid instruction in ID
//     id_rs{1,2,3}_i/_bank_i/_used_i  source index, bank, read enable
//     id_rd_i, id_rd_bank_i, id_rd_we_i  destination and write enable
//     id_multicycle_i             instruction goes to the multi-cycle unit
//     ex_load_i, ex_rd_i, ex_rd_bank_i  load currently in EX
//     mc_done_i, mc_rd_i, mc_rd_bank_i  multi-cycle writeback this cycle
//     stall_o                     combinational hold / bubble request
//     busy_int_o, busy_fp_o       pending bits per bank
//     outstanding_o               multi-cycle ops in flight
//     err_o                       sticky protocol error
// -----------------------------------------------------------------------------
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int MAX_OUTSTANDING = DEFAULT_MAX_OUTSTANDING,
   parameter int CNT_W           = DEFAULT_CNT_W
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic                 id_valid_i,
   input  logic [REG_IDX_W-1:0] id_rs1_i,
   input  logic [REG_IDX_W-1:0] id_rs2_i,
   input  logic [REG_IDX_W-1:0] id_rs3_i,
   input  logic                 id_rs1_bank_i,
   input  logic                 id_rs2_bank_i,
   input  logic                 id_rs3_bank_i,
   input  logic                 id_rs1_used_i,
   input  logic                 id_rs2_used_i,
   input  logic                 id_rs3_used_i,
   input  logic [REG_IDX_W-1:0] id_rd_i,
   input  logic                 id_rd_bank_i,
   input  logic                 id_rd_we_i,
   input  logic                 id_multicycle_i,
   input  logic                 ex_load_i,
   input  logic [REG_IDX_W-1:0] ex_rd_i,
   input  logic                 ex_rd_bank_i,
   input  logic                 mc_done_i,
   input  logic [REG_IDX_W-1:0] mc_rd_i,
   input  logic                 mc_rd_bank_i,
   output logic                 stall_o,
   output logic [31:0]          busy_int_o,
   output logic [31:0]          busy_fp_o,
   output logic [CNT_W-1:0]     outstanding_o,
   output logic                 err_o
);

   localparam logic [CNT_W-1:0] CAPACITY = MAX_OUTSTANDING[CNT_W-1:0];
   localparam logic [CNT_W-1:0] CNT_SAT  = '1;

   reg_ref_t   src   [3];
   logic [2:0] src_used;
   reg_ref_t   rd_ref;
   reg_ref_t   ex_ref;
   reg_ref_t   mc_ref;

   logic [2:0][REG_IDX_W-1:0] src_idx;
   logic [2:0] int_lookup_busy;
   logic [2:0] fp_lookup_busy;

   logic       issue;
   logic       raw_hazard;
   logic       waw_hazard;
   logic       load_use_hazard;
   logic       struct_hazard;
   logic       rd_busy;
   logic       mc_target_busy;
   logic       done_counted;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;

   assign src[0]   = '{bank: id_rs1_bank_i, idx: id_rs1_i};
   assign src[1]   = '{bank: id_rs2_bank_i, idx: id_rs2_i};
   assign src[2]   = '{bank: id_rs3_bank_i, idx: id_rs3_i};
   assign src_used = {id_rs3_used_i, id_rs2_used_i, id_rs1_used_i};
   assign src_idx  = {id_rs3_i, id_rs2_i, id_rs1_i};
   assign rd_ref   = '{bank: id_rd_bank_i, idx: id_rd_i};
   assign ex_ref   = '{bank: ex_rd_bank_i, idx: ex_rd_i};
   assign mc_ref   = '{bank: mc_rd_bank_i, idx: mc_rd_i};

   // ---------------------------------------------------------------------------
   // Busy storage, one instance per bank
   // ---------------------------------------------------------------------------
   scoreboard_bank #(.ZERO_REG0(1'b1)) u_bank_int (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .set_en      (issue && (id_rd_bank_i == BANK_INT)),
      .set_idx     (id_rd_i),
      .clr_en      (mc_done_i && (mc_rd_bank_i == BANK_INT)),
      .clr_idx     (mc_rd_i),
      .lookup_idx  (src_idx),
      .lookup_busy (int_lookup_busy),
      .busy        (busy_int_o)
   );

   scoreboard_bank #(.ZERO_REG0(1'b0)) u_bank_fp (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .set_en      (issue && (id_rd_bank_i == BANK_FP)),
      .set_idx     (id_rd_i),
      .clr_en      (mc_done_i && (mc_rd_bank_i == BANK_FP)),
      .clr_idx     (mc_rd_i),
      .lookup_idx  (src_idx),
      .lookup_busy (fp_lookup_busy),
      .busy        (busy_fp_o)
   );

   // ---------------------------------------------------------------------------
   // Hazard detection
   // ---------------------------------------------------------------------------
   always_comb begin
      raw_hazard      = 1'b0;
      load_use_hazard = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (src_used[i]) begin
            raw_hazard = raw_hazard |
               ((src[i].bank == BANK_FP) ? fp_lookup_busy[i] : int_lookup_busy[i]);
            load_use_hazard = load_use_hazard |
               (ex_load_i && ref_match(src[i], ex_ref) && !is_int_x0(ex_ref));
         end
      end
   end

   // Destination pending, with a writeback to the same register this cycle
   // treated as already complete.
   assign rd_busy = ((id_rd_bank_i == BANK_FP) ? busy_fp_o[id_rd_i] : busy_int_o[id_rd_i]) &
                    ~(mc_done_i && ref_match(rd_ref, mc_ref));

   assign waw_hazard    = id_rd_we_i && rd_busy;
   // A writeback this cycle frees a slot, so a full unit can still accept.
   assign struct_hazard = id_multicycle_i && (cnt_q == CAPACITY) && !mc_done_i;

   assign stall_o = id_valid_i &&
                    (raw_hazard || waw_hazard || load_use_hazard || struct_hazard);

   assign issue = id_valid_i && id_multicycle_i && id_rd_we_i && !stall_o;

   // ---------------------------------------------------------------------------
   // Outstanding counter and protocol error
   // ---------------------------------------------------------------------------
   assign mc_target_busy = (mc_rd_bank_i == BANK_FP) ? busy_fp_o[mc_rd_i] : busy_int_o[mc_rd_i];
   // A writeback with nothing in flight is an error and must not underflow.
   assign done_counted   = mc_done_i && (cnt_q != '0);

   always_comb begin
      cnt_d = cnt_q;
      unique case ({issue, done_counted})
         2'b10:   if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_comb begin
      err_d = err_q;
      if (mc_done_i && (cnt_q == '0)) err_d = 1'b1;
      if (mc_done_i && !mc_target_busy && !is_int_x0(mc_ref)) err_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign outstanding_o = cnt_q;
   assign err_o         = err_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_hazard_scoreboard
//   Directed self-checking bench for hazard_scoreboard (MAX_OUTSTANDING = 4).
//   Inputs change 1 time unit after a rising edge; combinational stall_o is
//   sampled 1 unit later, registered outputs 1 unit after the next edge.
// -----------------------------------------------------------------------------
module tb_hazard_scoreboard;

   logic       clk_i = 1'b0;
   logic       reset_i;
   logic       id_valid_i;
   logic [4:0] id_rs1_i, id_rs2_i, id_rs3_i;
   logic       id_rs1_bank_i, id_rs2_bank_i, id_rs3_bank_i;
   logic       id_rs1_used_i, id_rs2_used_i, id_rs3_used_i;
   logic [4:0] id_rd_i;
   logic       id_rd_bank_i;
   logic       id_rd_we_i;
   logic       id_multicycle_i;
   logic       ex_load_i;
   logic [4:0] ex_rd_i;
   logic       ex_rd_bank_i;
   logic       mc_done_i;
   logic [4:0] mc_rd_i;
   logic       mc_rd_bank_i;
   logic       stall_o;
   logic [31:0] busy_int_o, busy_fp_o;
   logic [2:0] outstanding_o;
   logic       err_o;

   int checks = 0;
   int errors = 0;

   always #5 clk_i = ~clk_i;

   hazard_scoreboard #(.MAX_OUTSTANDING(4), .CNT_W(3)) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .id_valid_i      (id_valid_i),
      .id_rs1_i        (id_rs1_i),
      .id_rs2_i        (id_rs2_i),
      .id_rs3_i        (id_rs3_i),
      .id_rs1_bank_i   (id_rs1_bank_i),
      .id_rs2_bank_i   (id_rs2_bank_i),
      .id_rs3_bank_i   (id_rs3_bank_i),
      .id_rs1_used_i   (id_rs1_used_i),
      .id_rs2_used_i   (id_rs2_used_i),
      .id_rs3_used_i   (id_rs3_used_i),
      .id_rd_i         (id_rd_i),
      .id_rd_bank_i    (id_rd_bank_i),
      .id_rd_we_i      (id_rd_we_i),
      .id_multicycle_i (id_multicycle_i),
      .ex_load_i       (ex_load_i),
      .ex_rd_i         (ex_rd_i),
      .ex_rd_bank_i    (ex_rd_bank_i),
      .mc_done_i       (mc_done_i),
      .mc_rd_i         (mc_rd_i),
      .mc_rd_bank_i    (mc_rd_bank_i),
      .stall_o         (stall_o),
      .busy_int_o      (busy_int_o),
      .busy_fp_o       (busy_fp_o),
      .outstanding_o   (outstanding_o),
      .err_o           (err_o)
   );

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      id_valid_i = 0; id_multicycle_i = 0; id_rd_we_i = 0;
      id_rs1_i = 0; id_rs2_i = 0; id_rs3_i = 0;
      id_rs1_bank_i = 0; id_rs2_bank_i = 0; id_rs3_bank_i = 0;
      id_rs1_used_i = 0; id_rs2_used_i = 0; id_rs3_used_i = 0;
      id_rd_i = 0; id_rd_bank_i = 0;
      ex_load_i = 0; ex_rd_i = 0; ex_rd_bank_i = 0;
      mc_done_i = 0; mc_rd_i = 0; mc_rd_bank_i = 0;
   endtask

   task automatic mc_issue(input logic [4:0] rd, input logic bank);
      id_valid_i = 1; id_multicycle_i = 1; id_rd_we_i = 1;
      id_rd_i = rd; id_rd_bank_i = bank;
   endtask

   task automatic done(input logic [4:0] rd, input logic bank);
      mc_done_i = 1; mc_rd_i = rd; mc_rd_bank_i = bank;
   endtask

   initial begin
      idle();
      reset_i = 1;
      tick(); tick();
      reset_i = 0;
      settle();

      // Reset state
      check("rst_busy_int", busy_int_o, 32'h0);
      check("rst_busy_fp", busy_fp_o, 32'h0);
      check("rst_outstanding", outstanding_o, 0);
      check("rst_err", err_o, 0);
      check("rst_stall", stall_o, 0);

      // fdiv f3 issue
      mc_issue(5'd3, 1'b1);
      settle();
      check("fdiv_issue_stall", stall_o, 0);
      tick();
      idle();
      settle();
      check("fdiv_busy_fp", busy_fp_o, 32'h0000_0008);
      check("fdiv_outstanding", outstanding_o, 1);

      // fadd f4 <- f3: RAW until writeback, bypass in the writeback cycle
      id_valid_i = 1; id_rs1_i = 3; id_rs1_bank_i = 1; id_rs1_used_i = 1;
      id_rd_i = 4; id_rd_bank_i = 1; id_rd_we_i = 1;
      settle();
      check("raw_stall_c0", stall_o, 1);
      tick();
      check("raw_stall_c1", stall_o, 1);
      done(5'd3, 1'b1);
      settle();
      check("raw_bypass", stall_o, 0);
      tick();
      idle();
      settle();
      check("done_busy_fp", busy_fp_o, 32'h0);
      check("done_outstanding", outstanding_o, 0);
      check("done_err", err_o, 0);

      // Bank isolation: f5 busy
      mc_issue(5'd5, 1'b1);
      tick();
      idle();
      id_valid_i = 1; id_rs1_i = 5; id_rs1_bank_i = 0; id_rs1_used_i = 1;
      settle();
      check("iso_int_x5", stall_o, 0);
      id_rs1_used_i = 0;
      id_rs3_i = 5; id_rs3_bank_i = 1; id_rs3_used_i = 1;
      settle();
      check("iso_f5_rs3_used", stall_o, 1);
      id_rs3_used_i = 0;
      settle();
      check("iso_f5_rs3_unused", stall_o, 0);
      id_rd_i = 5; id_rd_bank_i = 1; id_rd_we_i = 1;
      settle();
      check("waw_f5", stall_o, 1);
      idle();

      // Load-use
      ex_load_i = 1; ex_rd_i = 7; ex_rd_bank_i = 0;
      id_valid_i = 1; id_rs2_i = 7; id_rs2_bank_i = 0; id_rs2_used_i = 1;
      settle();
      check("load_use_x7", stall_o, 1);
      ex_rd_i = 0; id_rs2_i = 0;
      settle();
      check("load_use_x0", stall_o, 0);
      idle();
      tick();

      // Capacity: f5 in flight, add x0 (counted, no bit), x10, f6
      mc_issue(5'd0, 1'b0);
      tick();
      mc_issue(5'd10, 1'b0);
      tick();
      mc_issue(5'd6, 1'b1);
      tick();
      idle();
      settle();
      check("cap_outstanding", outstanding_o, 4);
      check("cap_busy_int", busy_int_o, 32'h0000_0400);
      check("cap_busy_fp", busy_fp_o, 32'h0000_0060);
      mc_issue(5'd7, 1'b1);
      settle();
      check("cap_full_stall", stall_o, 1);
      done(5'd5, 1'b1);
      settle();
      check("cap_done_no_stall", stall_o, 0);
      tick();
      idle();
      settle();
      check("cap_swap_outstanding", outstanding_o, 4);
      check("cap_swap_busy_fp", busy_fp_o, 32'h0000_00C0);
      check("cap_swap_err", err_o, 0);

      // Drain, including the x0 completion which is not an error
      done(5'd10, 1'b0); tick();
      done(5'd6, 1'b1);  tick();
      done(5'd7, 1'b1);  tick();
      done(5'd0, 1'b0);  tick();
      idle();
      settle();
      check("drain_outstanding", outstanding_o, 0);
      check("drain_busy_int", busy_int_o, 32'h0);
      check("drain_busy_fp", busy_fp_o, 32'h0);
      check("drain_err", err_o, 0);

      // Simultaneous issue and done on f2
      mc_issue(5'd2, 1'b1);
      tick();
      done(5'd2, 1'b1);
      settle();
      check("same_reg_stall", stall_o, 0);
      tick();
      idle();
      settle();
      check("same_reg_busy_fp", busy_fp_o, 32'h0000_0004);
      check("same_reg_outstanding", outstanding_o, 1);
      check("same_reg_err", err_o, 0);
      done(5'd2, 1'b1);
      tick();
      idle();
      settle();
      check("f2_done_outstanding", outstanding_o, 0);

      // Spurious completion
      done(5'd9, 1'b1);
      tick();
      idle();
      settle();
      check("spurious_err", err_o, 1);
      check("spurious_outstanding", outstanding_o, 0);

      // Reset mid-operation with a completion pending
      mc_issue(5'd1, 1'b0); tick();
      mc_issue(5'd2, 1'b0); tick();
      mc_issue(5'd1, 1'b1); tick();
      idle();
      settle();
      check("pre_rst_outstanding", outstanding_o, 3);
      reset_i = 1;
      done(5'd1, 1'b0);
      tick();
      reset_i = 0;
      idle();
      settle();
      check("mid_rst_busy_int", busy_int_o, 32'h0);
      check("mid_rst_busy_fp", busy_fp_o, 32'h0);
      check("mid_rst_outstanding", outstanding_o, 0);
      check("mid_rst_err", err_o, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
